// File: rtl/unet_layer_scheduler.sv
// Layer sequencer: feeds per-layer descriptors to the convolution controller and handshakes BeginConv/ConvDone.
// Optional watchdog: define SCHED_TIMEOUT_EN to enable the TIMEOUT limit and the sticky err flag.
module unet_layer_scheduler #(
    parameter int          MAX_LAYERS = 8,
    parameter int          LAYER_W    = 3,
    parameter int          BEGIN_HOLD = 2,
    parameter logic [31:0] TIMEOUT    = 32'd4000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [LAYER_W-1:0] cfg_layer,
    input  logic [1:0]         cfg_field,
    input  logic [31:0]        cfg_wdata,
    input  logic [LAYER_W:0]   num_layers,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [LAYER_W-1:0] cur_layer,
    output logic               err,
    output logic [31:0]        InputImageAddress,
    output logic [31:0]        OutputImageAddress,
    output logic [31:0]        WeightAddress,
    output logic [7:0]         heightOfImage,
    output logic [7:0]         widthOfImage,
    output logic               BeginConv,
    input  logic               ConvDone
);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DONE} state_t;

    localparam int HOLD_W = $clog2(BEGIN_HOLD + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(BEGIN_HOLD - 1);
    localparam logic [LAYER_W:0]   MAX_N     = (LAYER_W+1)'(MAX_LAYERS);

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                beg_q, beg_d;
    logic [LAYER_W-1:0]  cur_q, cur_d;
    logic [LAYER_W-1:0]  idx_q, idx_d;
    logic [LAYER_W:0]    nl_q, nl_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                pend_q, pend_d;
    logic                cd_prev_q, cd_prev_d;
    logic [31:0]         in_q, in_d, out_q, out_d, wt_q, wt_d;
    logic [15:0]         dim_q, dim_d;
    logic [31:0]         in_tbl_q  [MAX_LAYERS];
    logic [31:0]         in_tbl_d  [MAX_LAYERS];
    logic [31:0]         out_tbl_q [MAX_LAYERS];
    logic [31:0]         out_tbl_d [MAX_LAYERS];
    logic [31:0]         wt_tbl_q  [MAX_LAYERS];
    logic [31:0]         wt_tbl_d  [MAX_LAYERS];
    logic [15:0]         dim_tbl_q [MAX_LAYERS];
    logic [15:0]         dim_tbl_d [MAX_LAYERS];
    logic                conv_edge;
    logic                last_layer;
    logic [LAYER_W:0]    nl_clamp;
`ifdef SCHED_TIMEOUT_EN
    logic [31:0]         wd_q, wd_d;
    logic                err_q, err_d;
`endif

    // ConvDone is sticky, so only its rising edge marks completion.
    assign conv_edge  = ConvDone & ~cd_prev_q;
    assign last_layer = ({1'b0, idx_q} == (nl_q - (LAYER_W+1)'(1)));
    assign nl_clamp   = (num_layers > MAX_N) ? MAX_N : num_layers;

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        beg_d     = beg_q;
        cur_d     = cur_q;
        idx_d     = idx_q;
        nl_d      = nl_q;
        hold_d    = hold_q;
        pend_d    = pend_q;
        cd_prev_d = ConvDone;
        in_d      = in_q;
        out_d     = out_q;
        wt_d      = wt_q;
        dim_d     = dim_q;
        in_tbl_d  = in_tbl_q;
        out_tbl_d = out_tbl_q;
        wt_tbl_d  = wt_tbl_q;
        dim_tbl_d = dim_tbl_q;
`ifdef SCHED_TIMEOUT_EN
        wd_d      = wd_q;
        err_d     = err_q;
`endif

        if (cfg_we && !busy_q && ({1'b0, cfg_layer} < MAX_N)) begin
            case (cfg_field)
                2'd0:    in_tbl_d[cfg_layer]  = cfg_wdata;
                2'd1:    out_tbl_d[cfg_layer] = cfg_wdata;
                2'd2:    wt_tbl_d[cfg_layer]  = cfg_wdata;
                default: dim_tbl_d[cfg_layer] = cfg_wdata[15:0];
            endcase
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    nl_d = nl_clamp;
`ifdef SCHED_TIMEOUT_EN
                    err_d = 1'b0;
`endif
                    if (nl_clamp == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOAD;
                        busy_d  = 1'b1;
                        idx_d   = '0;
                    end
                end
            end
            LOAD: begin
                in_d    = in_tbl_q[idx_q];
                out_d   = out_tbl_q[idx_q];
                wt_d    = wt_tbl_q[idx_q];
                dim_d   = dim_tbl_q[idx_q];
                cur_d   = idx_q;
                beg_d   = 1'b1;
                hold_d  = '0;
                pend_d  = 1'b0;
                state_d = ISSUE;
`ifdef SCHED_TIMEOUT_EN
                wd_d    = '0;
`endif
            end
            ISSUE: begin
                // A completion edge seen while BeginConv is still held is kept for WAIT.
                if (conv_edge) pend_d = 1'b1;
                if (hold_q == HOLD_LAST) begin
                    beg_d   = 1'b0;
                    state_d = WAIT;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            WAIT: begin
                if (conv_edge || pend_q) begin
                    pend_d = 1'b0;
                    if (last_layer) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + LAYER_W'(1);
                        state_d = LOAD;
                    end
                end
`ifdef SCHED_TIMEOUT_EN
                else if (wd_q == TIMEOUT - 32'd1) begin
                    err_d   = 1'b1;
                    beg_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    wd_d = wd_q + 32'd1;
                end
`endif
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            beg_q     <= 1'b0;
            cur_q     <= '0;
            idx_q     <= '0;
            nl_q      <= '0;
            hold_q    <= '0;
            pend_q    <= 1'b0;
            cd_prev_q <= 1'b0;
            in_q      <= '0;
            out_q     <= '0;
            wt_q      <= '0;
            dim_q     <= '0;
            for (int i = 0; i < MAX_LAYERS; i++) begin
                in_tbl_q[i]  <= '0;
                out_tbl_q[i] <= '0;
                wt_tbl_q[i]  <= '0;
                dim_tbl_q[i] <= '0;
            end
`ifdef SCHED_TIMEOUT_EN
            wd_q      <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            beg_q     <= beg_d;
            cur_q     <= cur_d;
            idx_q     <= idx_d;
            nl_q      <= nl_d;
            hold_q    <= hold_d;
            pend_q    <= pend_d;
            cd_prev_q <= cd_prev_d;
            in_q      <= in_d;
            out_q     <= out_d;
            wt_q      <= wt_d;
            dim_q     <= dim_d;
            in_tbl_q  <= in_tbl_d;
            out_tbl_q <= out_tbl_d;
            wt_tbl_q  <= wt_tbl_d;
            dim_tbl_q <= dim_tbl_d;
`ifdef SCHED_TIMEOUT_EN
            wd_q      <= wd_d;
            err_q     <= err_d;
`endif
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign cur_layer          = cur_q;
    assign BeginConv          = beg_q;
    assign InputImageAddress  = in_q;
    assign OutputImageAddress = out_q;
    assign WeightAddress      = wt_q;
    assign heightOfImage      = dim_q[15:8];
    assign widthOfImage       = dim_q[7:0];
`ifdef SCHED_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_unet_layer_scheduler.sv
// Bench for unet_layer_scheduler: latency-schedule model checked every cycle, plus literal run checks.
module tb_unet_layer_scheduler;

    localparam int HOLD = 2;
    localparam int MAXL = 8;
`ifdef SCHED_TIMEOUT_EN
    localparam int TO = 100;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_layer = '0;
    logic [1:0]  cfg_field = '0;
    logic [31:0] cfg_wdata = '0;
    logic [3:0]  num_layers = '0;
    logic        start = 1'b0;
    logic        ConvDone = 1'b0;
    logic        busy, done, err, BeginConv;
    logic [2:0]  cur_layer;
    logic [31:0] InputImageAddress, OutputImageAddress, WeightAddress;
    logic [7:0]  heightOfImage, widthOfImage;

    unet_layer_scheduler #(.TIMEOUT(32'd100)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_layer(cfg_layer),
        .cfg_field(cfg_field), .cfg_wdata(cfg_wdata), .num_layers(num_layers),
        .start(start), .busy(busy), .done(done), .cur_layer(cur_layer), .err(err),
        .InputImageAddress(InputImageAddress), .OutputImageAddress(OutputImageAddress),
        .WeightAddress(WeightAddress), .heightOfImage(heightOfImage),
        .widthOfImage(widthOfImage), .BeginConv(BeginConv), .ConvDone(ConvDone)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: outputs derived from the start/ConvDone latency rules and a descriptor table.
    logic [31:0] t_in [MAXL];
    logic [31:0] t_out[MAXL];
    logic [31:0] t_w  [MAXL];
    logic [15:0] t_dim[MAXL];
    bit          m_busy, m_done, m_beg, m_err;
    logic [2:0]  m_layer;
    logic [31:0] m_in, m_out, m_w;
    logic [15:0] m_dim;
    bit          running, got, cd_prev, cd_edge;
    int          mk = 0, m_n, m_idx, beg_at, ready_at, done_at;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_beg = 0; m_err = 0; m_layer = '0;
            m_in = '0; m_out = '0; m_w = '0; m_dim = '0;
            for (int i = 0; i < MAXL; i++) begin
                t_in[i] = '0; t_out[i] = '0; t_w[i] = '0; t_dim[i] = '0;
            end
            running = 0; got = 0; cd_prev = 0; ready_at = 0; done_at = -1;
            m_n = 0; m_idx = 0; beg_at = -100;
        end else begin
            mk++;
            cd_edge = ConvDone && !cd_prev;
            cd_prev = ConvDone;
            if (cfg_we && !m_busy && int'(cfg_layer) < MAXL) begin
                case (cfg_field)
                    2'd0: t_in[cfg_layer] = cfg_wdata;
                    2'd1: t_out[cfg_layer] = cfg_wdata;
                    2'd2: t_w[cfg_layer] = cfg_wdata;
                    default: t_dim[cfg_layer] = cfg_wdata[15:0];
                endcase
            end
            m_done = 0;
            if (mk == done_at) begin
                m_done = 1;
                m_busy = 0;
            end
            if (running) begin
                if (mk == beg_at) begin
                    m_in = t_in[m_idx]; m_out = t_out[m_idx]; m_w = t_w[m_idx];
                    m_dim = t_dim[m_idx]; m_layer = 3'(m_idx); m_beg = 1;
                end
                if (mk == beg_at + HOLD) m_beg = 0;
                if (cd_edge && mk >= beg_at + 1) got = 1;
                if (got && mk >= beg_at + 1 + HOLD) begin
                    got = 0;
                    if (m_idx == m_n - 1) begin
                        running = 0; done_at = mk + 1; ready_at = mk + 2;
                    end else begin
                        m_idx++; beg_at = mk + 1;
                    end
                end
`ifdef SCHED_TIMEOUT_EN
                else if (mk == beg_at + HOLD + TO) begin
                    m_err = 1; running = 0; done_at = mk + 1; ready_at = mk + 2;
                end
`endif
            end else if (mk >= ready_at && start) begin
                m_err = 0;
                m_n = (int'(num_layers) > MAXL) ? MAXL : int'(num_layers);
                if (m_n == 0) begin
                    done_at = mk + 1; ready_at = mk + 2;
                end else begin
                    running = 1; m_busy = 1; m_idx = 0; beg_at = mk + 1; got = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("BeginConv", 32'(BeginConv), 32'(m_beg));
        chk("err", 32'(err), 32'(m_err));
        chk("cur_layer", 32'(cur_layer), 32'(m_layer));
        chk("InputImageAddress", InputImageAddress, m_in);
        chk("OutputImageAddress", OutputImageAddress, m_out);
        chk("WeightAddress", WeightAddress, m_w);
        chk("heightOfImage", 32'(heightOfImage), 32'(m_dim[15:8]));
        chk("widthOfImage", 32'(widthOfImage), 32'(m_dim[7:0]));
    end

    // Controller stand-in: drops ConvDone on a BeginConv rise, raises it (sticky) 50 cycles later.
    bit ctl_en = 1;
    bit ctl_bprev = 0;
    int ctl_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            ConvDone = 0; ctl_cnt = 0; ctl_bprev = 0;
        end else if (!ctl_en) begin
            ConvDone = 0; ctl_cnt = 0; ctl_bprev = BeginConv;
        end else begin
            if (BeginConv && !ctl_bprev) begin
                ConvDone = 0; ctl_cnt = 50;
            end else if (ctl_cnt > 0) begin
                ctl_cnt--;
                if (ctl_cnt == 0) ConvDone = 1;
            end
            ctl_bprev = BeginConv;
        end
    end

    // Run monitor.
    int beg_rises, beg_high, done_pulses, done_cyc, cd_rises;
    int beg_cyc[16], beg_lay[16], cdr_cyc[16];
    logic [31:0] beg_in[16], beg_out[16], beg_w[16];
    logic [7:0] beg_h[16], beg_wd[16];
    bit mon_bprev = 0, mon_cprev = 0;
    always @(negedge clk) begin
        if (BeginConv) beg_high++;
        if (BeginConv && !mon_bprev && beg_rises < 16) begin
            beg_cyc[beg_rises] = cyc; beg_lay[beg_rises] = int'(cur_layer);
            beg_in[beg_rises] = InputImageAddress; beg_out[beg_rises] = OutputImageAddress;
            beg_w[beg_rises] = WeightAddress; beg_h[beg_rises] = heightOfImage;
            beg_wd[beg_rises] = widthOfImage;
            beg_rises++;
        end
        if (ConvDone && !mon_cprev && cd_rises < 16) begin
            cdr_cyc[cd_rises] = cyc; cd_rises++;
        end
        if (done) begin done_pulses++; done_cyc = cyc; end
        mon_bprev = BeginConv;
        mon_cprev = ConvDone;
    end

    task automatic clr_mon();
        beg_rises = 0; beg_high = 0; done_pulses = 0; done_cyc = -1; cd_rises = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int l, input int f, input logic [31:0] d);
        cfg_we = 1; cfg_layer = 3'(l); cfg_field = 2'(f); cfg_wdata = d;
        step();
        cfg_we = 0;
    endtask

    int start_cyc;
    task automatic run_start(input logic [3:0] n);
        num_layers = n; start = 1; start_cyc = cyc;
        step();
        start = 0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL %s: no done pulse within %0d cycles", nm, budget);
        end
        step(); step();
    endtask

    task automatic wait_beg(input int target, input int budget, input string nm);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (beg_rises >= target) seen = 1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL %s: BeginConv rise %0d not seen within %0d cycles", nm, target, budget);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        clr_mon();
        #2 rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        step();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_addr", InputImageAddress, 32'd0);

        for (int i = 0; i < 3; i++) begin
            cfg_write(i, 0, 32'h1000 * (i + 1));
            cfg_write(i, 1, 32'h8000 + 32'h1000 * i);
            cfg_write(i, 2, 32'h100);
            cfg_write(i, 3, 32'hABCD_8080);
        end

        // Three-layer run.
        clr_mon();
        run_start(4'd3);
        wait_done(400, "run3_done");
        chk("run3_beg_count", 32'(beg_rises), 32'd3);
        chk("run3_beg_high", 32'(beg_high), 32'd6);
        chk("run3_done_count", 32'(done_pulses), 32'd1);
        chk("run3_start_lat", 32'(beg_cyc[0] - start_cyc), 32'd2);
        chk("run3_in0", beg_in[0], 32'h1000);
        chk("run3_in1", beg_in[1], 32'h2000);
        chk("run3_in2", beg_in[2], 32'h3000);
        chk("run3_out2", beg_out[2], 32'hA000);
        chk("run3_w1", beg_w[1], 32'h100);
        chk("run3_dims", {beg_h[2], beg_wd[2]}, 32'h8080);
        chk("run3_layer1", 32'(beg_lay[1]), 32'd1);
        chk("run3_layer2", 32'(beg_lay[2]), 32'd2);
        chk("run3_cd_to_beg", 32'(beg_cyc[1] - cdr_cyc[0]), 32'd2);
        chk("run3_cd_to_done", 32'(done_cyc - cdr_cyc[2]), 32'd2);
        chk("run3_busy_after", 32'(busy), 32'd0);
        chk("run3_hold_addr", InputImageAddress, 32'h3000);

        // ConvDone still high from previous run: only the next rising edge may finish.
        chk("stale_cd_high", 32'(ConvDone), 32'd1);
        clr_mon();
        run_start(4'd1);
        wait_done(200, "stale_done");
        chk("stale_beg_count", 32'(beg_rises), 32'd1);
        chk("stale_beg_to_done", 32'(done_cyc - beg_cyc[0]), 32'd52);

        // Config write to layer 1 while busy in layer 0 must be dropped.
        clr_mon();
        run_start(4'd2);
        wait_beg(1, 20, "busywr_beg0");
        cfg_write(1, 0, 32'hDEAD_0000);
        wait_done(300, "busywr_done");
        chk("busywr_in1", beg_in[1], 32'h2000);

        // Zero-layer run.
        clr_mon();
        run_start(4'd0);
        wait_done(10, "zero_done");
        chk("zero_beg_count", 32'(beg_rises), 32'd0);
        chk("zero_done_count", 32'(done_pulses), 32'd1);
        chk("zero_done_lat", 32'(done_cyc - start_cyc), 32'd2);

        // num_layers above MAX_LAYERS clamps.
        clr_mon();
        run_start(4'd12);
        wait_done(800, "clamp_done");
        chk("clamp_beg_count", 32'(beg_rises), 32'd8);
        chk("clamp_last_layer", 32'(beg_lay[7]), 32'd7);

        // Reset during WAIT of layer 1, then a fresh run from layer 0 with a cleared table.
        clr_mon();
        run_start(4'd3);
        begin
            bit hit = 0;
            for (int i = 0; i < 200 && !hit; i++) begin
                @(negedge clk);
                if (busy && cur_layer == 3'd1 && !BeginConv) hit = 1;
            end
            n_cmp++;
            if (!hit) begin
                n_bad++;
                $display("FAIL rst_reach_wait1: layer 1 WAIT not reached");
            end
        end
        #1 rst_n = 0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_layer", 32'(cur_layer), 32'd0);
        chk("rst_in", InputImageAddress, 32'd0);
        @(negedge clk);
        #1 rst_n = 1;
        step();
        clr_mon();
        run_start(4'd1);
        wait_beg(1, 20, "rst_fresh_beg");
        chk("rst_fresh_layer", 32'(beg_lay[0]), 32'd0);
        chk("rst_fresh_in", beg_in[0], 32'd0);
        wait_done(200, "rst_fresh_done");

`ifdef SCHED_TIMEOUT_EN
        // Watchdog: no ConvDone at all.
        ctl_en = 0;
        step(); step();
        clr_mon();
        run_start(4'd1);
        wait_done(300, "to_done");
        chk("to_err", 32'(err), 32'd1);
        chk("to_lat", 32'(done_cyc - beg_cyc[0]), 32'd103);
        run_start(4'd0);
        chk("to_err_cleared", 32'(err), 32'd0);
        wait_done(10, "to_clear_done");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
